// File: rtl/nic_fifo_if.sv
// nic_fifo_if: CPU register port and router channel signals of the NIC FIFO
interface nic_fifo_if #(
    parameter int PACKET_WIDTH = 64
);
    logic [1:0]              addr;
    logic [0:PACKET_WIDTH-1] d_in;
    logic [0:PACKET_WIDTH-1] d_out;
    logic                    nicEn;
    logic                    nicEnWR;
    logic                    net_si;
    logic                    net_ri;
    logic [0:PACKET_WIDTH-1] net_di;
    logic                    net_so;
    logic                    net_ro;
    logic [0:PACKET_WIDTH-1] net_do;
    logic                    net_polarity;

    modport master (
        output addr, d_in, nicEn, nicEnWR, net_si, net_di, net_ro, net_polarity,
        input  d_out, net_ri, net_so, net_do
    );

    modport slave (
        input  addr, d_in, nicEn, nicEnWR, net_si, net_di, net_ro, net_polarity,
        output d_out, net_ri, net_so, net_do
    );
endinterface

// File: rtl/nic_fifo.sv
// nic_fifo: router->CPU input FIFO and CPU->router output FIFO with CPU register access
module nic_fifo #(
    parameter int PACKET_WIDTH = 64,
    parameter int DEPTH        = 4
) (
    input logic       clk,
    input logic       reset,
    nic_fifo_if.slave bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [0:PACKET_WIDTH-1] imem_q [DEPTH];
    logic [0:PACKET_WIDTH-1] omem_q [DEPTH];
    logic [PW-1:0]           ird_q, ird_d, iwr_q, iwr_d, ord_q, ord_d, owr_q, owr_d;
    logic [CW-1:0]           icnt_q, icnt_d, ocnt_q, ocnt_d;
    logic                    wr_drop_q, wr_drop_d, net_so_q, net_so_d;
    logic [0:PACKET_WIDTH-1] d_out_q, d_out_d, net_do_q, net_do_d, stat;
    logic                    rd, wr, ipush, ipop, opush, opop;

    assign bus.net_ri = icnt_q < FULL;
    assign bus.d_out  = d_out_q;
    assign bus.net_so = net_so_q;
    assign bus.net_do = net_do_q;

    // Full/empty decisions use pre-edge counts, so a same-cycle pop never frees room for a push
    always_comb begin
        rd        = bus.nicEn && !bus.nicEnWR;
        wr        = bus.nicEn && bus.nicEnWR;
        ipush     = bus.net_si && icnt_q < FULL;
        ipop      = rd && bus.addr == 2'b00 && icnt_q != '0;
        opush     = wr && bus.addr == 2'b10 && ocnt_q != FULL;
        opop      = ocnt_q != '0 && bus.net_ro && bus.net_polarity;
        iwr_d     = ipush ? iwr_q + PW'(1) : iwr_q;
        ird_d     = ipop ? ird_q + PW'(1) : ird_q;
        owr_d     = opush ? owr_q + PW'(1) : owr_q;
        ord_d     = opop ? ord_q + PW'(1) : ord_q;
        icnt_d    = icnt_q + CW'(ipush) - CW'(ipop);
        ocnt_d    = ocnt_q + CW'(opush) - CW'(opop);
        wr_drop_d = wr && bus.addr == 2'b11 ? 1'b0 :
                    wr && bus.addr == 2'b10 && ocnt_q == FULL ? 1'b1 : wr_drop_q;
        stat      = PACKET_WIDTH'(ocnt_q) | (PACKET_WIDTH'(wr_drop_q) << CW);
        d_out_d   = !rd                ? d_out_q :
                    bus.addr == 2'b00  ? (ipop ? imem_q[ird_q] : '0) :
                    bus.addr == 2'b01  ? PACKET_WIDTH'(icnt_q) :
                    bus.addr == 2'b11  ? stat : '0;
        net_so_d  = opop;
        net_do_d  = opop ? omem_q[ord_q] : net_do_q;
    end

    always_ff @(posedge clk) begin
        if (ipush) imem_q[iwr_q] <= bus.net_di;
        if (opush) omem_q[owr_q] <= bus.d_in;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ird_q     <= '0;
            iwr_q     <= '0;
            ord_q     <= '0;
            owr_q     <= '0;
            icnt_q    <= '0;
            ocnt_q    <= '0;
            wr_drop_q <= 1'b0;
            net_so_q  <= 1'b0;
            d_out_q   <= '0;
            net_do_q  <= '0;
        end else begin
            ird_q     <= ird_d;
            iwr_q     <= iwr_d;
            ord_q     <= ord_d;
            owr_q     <= owr_d;
            icnt_q    <= icnt_d;
            ocnt_q    <= ocnt_d;
            wr_drop_q <= wr_drop_d;
            net_so_q  <= net_so_d;
            d_out_q   <= d_out_d;
            net_do_q  <= net_do_d;
        end
    end
endmodule

// File: tb/tb_nic_fifo.sv
// tb_nic_fifo: directed checks of the NIC FIFO with DEPTH=4, PACKET_WIDTH=64
module tb_nic_fifo;
    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   passed = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    nic_fifo_if #(.PACKET_WIDTH(64)) bus ();
    nic_fifo #(.PACKET_WIDTH(64), .DEPTH(4)) dut (.clk(clk), .reset(reset), .bus(bus));

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic rd(input logic [1:0] a);
        bus.nicEn = 1'b1; bus.nicEnWR = 1'b0; bus.addr = a;
        cyc();
        bus.nicEn = 1'b0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [63:0] d);
        bus.nicEn = 1'b1; bus.nicEnWR = 1'b1; bus.addr = a; bus.d_in = d;
        cyc();
        bus.nicEn = 1'b0; bus.nicEnWR = 1'b0;
    endtask

    task automatic push(input logic [63:0] d);
        bus.net_si = 1'b1; bus.net_di = d;
        cyc();
        bus.net_si = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        bus.addr = 2'b00; bus.d_in = '0; bus.nicEn = 1'b0; bus.nicEnWR = 1'b0;
        bus.net_si = 1'b0; bus.net_di = '0; bus.net_ro = 1'b0; bus.net_polarity = 1'b0;
        cyc(); cyc();
        reset = 1'b0;
        chk("rst_d_out", bus.d_out, 64'h0);
        chk("rst_net_so", 64'(bus.net_so), 64'h0);
        chk("rst_net_do", bus.net_do, 64'h0);
        chk("rst_net_ri", 64'(bus.net_ri), 64'h1);

        // Router fills IFIFO, fifth send ignored, CPU drains in order
        push(64'hA); push(64'hB); push(64'hC);
        chk("ri_3", 64'(bus.net_ri), 64'h1);
        push(64'hD);
        chk("ri_full", 64'(bus.net_ri), 64'h0);
        push(64'hE);
        rd(2'b01);
        chk("icnt_full", bus.d_out, 64'h4);
        rd(2'b00); chk("pop_A", bus.d_out, 64'hA);
        chk("ri_after_pop", 64'(bus.net_ri), 64'h1);
        rd(2'b00); chk("pop_B", bus.d_out, 64'hB);
        rd(2'b00); chk("pop_C", bus.d_out, 64'hC);
        rd(2'b00); chk("pop_D", bus.d_out, 64'hD);
        rd(2'b00); chk("pop_empty", bus.d_out, 64'h0);
        rd(2'b10); chk("addr10_read", bus.d_out, 64'h0);

        // Output channel paced by polarity
        bus.net_ro = 1'b1; bus.net_polarity = 1'b0;
        wr(2'b10, 64'h11);
        wr(2'b10, 64'h22);
        chk("so_pol0_idle", 64'(bus.net_so), 64'h0);
        bus.net_polarity = 1'b1; cyc();
        chk("so_1", 64'(bus.net_so), 64'h1);
        chk("do_1", bus.net_do, 64'h11);
        bus.net_polarity = 1'b0; cyc();
        chk("so_pol0", 64'(bus.net_so), 64'h0);
        chk("do_hold", bus.net_do, 64'h11);
        bus.net_polarity = 1'b1; cyc();
        chk("so_2", 64'(bus.net_so), 64'h1);
        chk("do_2", bus.net_do, 64'h22);
        cyc();
        chk("so_empty", 64'(bus.net_so), 64'h0);
        bus.net_ro = 1'b0;
        rd(2'b11); chk("ocnt_zero", bus.d_out, 64'h0);

        // Overflowing OFIFO sets sticky drop; writes to 00/01 ignored
        wr(2'b00, 64'h99); wr(2'b01, 64'h99);
        rd(2'b11); chk("ignored_wr", bus.d_out, 64'h0);
        for (int i = 1; i <= 5; i++) wr(2'b10, 64'(i));
        rd(2'b11); chk("ofull_drop", bus.d_out, 64'hC);
        rd(2'b01); rd(2'b11); chk("drop_sticky", bus.d_out, 64'hC);
        wr(2'b11, 64'h0);
        rd(2'b11); chk("drop_clr", bus.d_out, 64'h4);
        bus.net_ro = 1'b1; bus.net_polarity = 1'b1;
        cyc(); chk("drain_1", bus.net_do, 64'h1);
        cyc(); chk("drain_2", bus.net_do, 64'h2);
        cyc(); chk("drain_3", bus.net_do, 64'h3);
        cyc(); chk("drain_4", bus.net_do, 64'h4);
        cyc(); chk("drain_end_so", 64'(bus.net_so), 64'h0);
        bus.net_ro = 1'b0;

        // Full IFIFO: same-cycle push and pop -> pop only
        push(64'h10); push(64'h20); push(64'h30); push(64'h40);
        bus.net_si = 1'b1; bus.net_di = 64'h50;
        rd(2'b00);
        bus.net_si = 1'b0;
        chk("simul_pop", bus.d_out, 64'h10);
        rd(2'b01); chk("simul_cnt", bus.d_out, 64'h3);
        rd(2'b00); chk("simul_20", bus.d_out, 64'h20);
        rd(2'b00); chk("simul_30", bus.d_out, 64'h30);
        rd(2'b00); chk("simul_40", bus.d_out, 64'h40);
        rd(2'b00); chk("simul_rej", bus.d_out, 64'h0);

        // Reset mid-operation with both FIFOs at count 2
        push(64'hA1); push(64'hA2);
        wr(2'b10, 64'hB1); wr(2'b10, 64'hB2);
        rd(2'b01); chk("pre_rst_cnt", bus.d_out, 64'h2);
        reset = 1'b1; bus.net_si = 1'b1; bus.net_di = 64'hA3;
        bus.net_ro = 1'b1; bus.net_polarity = 1'b1;
        rd(2'b00);
        reset = 1'b0; bus.net_si = 1'b0; bus.net_ro = 1'b0;
        chk("mid_rst_d_out", bus.d_out, 64'h0);
        chk("mid_rst_so", 64'(bus.net_so), 64'h0);
        chk("mid_rst_do", bus.net_do, 64'h0);
        chk("mid_rst_ri", 64'(bus.net_ri), 64'h1);
        rd(2'b01); chk("mid_rst_icnt", bus.d_out, 64'h0);
        rd(2'b11); chk("mid_rst_ocnt", bus.d_out, 64'h0);
        wr(2'b10, 64'h77);
        bus.net_ro = 1'b1; cyc();
        chk("post_rst_so", 64'(bus.net_so), 64'h1);
        chk("post_rst_do", bus.net_do, 64'h77);
        cyc();
        chk("post_rst_one", 64'(bus.net_so), 64'h0);
        bus.net_ro = 1'b0;

        // All-zero packets count as real data
        push(64'h0);
        rd(2'b01); chk("zero_icnt", bus.d_out, 64'h1);
        rd(2'b00); chk("zero_pop", bus.d_out, 64'h0);
        rd(2'b01); chk("zero_icnt_after", bus.d_out, 64'h0);
        wr(2'b10, 64'h0);
        rd(2'b11); chk("zero_ocnt", bus.d_out, 64'h1);
        bus.net_ro = 1'b1; cyc();
        chk("zero_so", 64'(bus.net_so), 64'h1);
        chk("zero_do", bus.net_do, 64'h0);
        bus.net_ro = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/nic_fifo.md
NIC_FIFO -- requirements
Module: nic_fifo

Interface
REQ-001 SHALL have parameter PACKET_WIDTH, default 64, meaning packet width in bits, with bit 0 as MSB and bit PACKET_WIDTH-1 as LSB.
REQ-002 SHALL have parameter DEPTH, default 4, meaning entries per channel FIFO; power of two, >=2.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port addr  input  2  CPU register select.
REQ-006 SHALL have port d_in  input  PACKET_WIDTH  CPU write data.
REQ-007 SHALL have port d_out  output  PACKET_WIDTH  registered CPU read data.
REQ-008 SHALL have port nicEn  input  1  CPU access enable.
REQ-009 SHALL have port nicEnWR  input  1  CPU write qualifier.
REQ-010 SHALL have port net_si  input  1  router send strobe into the input channel.
REQ-011 SHALL have port net_ri  output  1  input-channel ready.
REQ-012 SHALL have port net_di  input  PACKET_WIDTH  router packet into the input channel.
REQ-013 SHALL have port net_so  output  1  output-channel send strobe.
REQ-014 SHALL have port net_ro  input  1  router ready for the output channel.
REQ-015 SHALL have port net_do  output  PACKET_WIDTH  output-channel packet.
REQ-016 SHALL have port net_polarity  input  1  router polarity; a send is allowed only when it is 1.

Function
REQ-017 SHALL hold two DEPTH-entry circular FIFOs: IFIFO (router->CPU) and OFIFO (CPU->router); each with read pointer, write pointer and count of width clog2(DEPTH+1); pointers wrap DEPTH-1 -> 0.
REQ-018 SHALL drive net_ri combinationally = (IFIFO count < DEPTH); it is independent of net_si.
REQ-019 SHALL, on a cycle with net_si && net_ri, push net_di into IFIFO; net_si while not ready has no effect.
REQ-020 SHALL treat a read as nicEn && !nicEnWR and update d_out on the next edge; with no read, d_out holds its value.
REQ-021 SHALL, for a read with addr 00 and IFIFO non-empty, load the IFIFO head into d_out and pop it; with IFIFO empty, load 0 and pop nothing.
REQ-022 SHALL, for a read with addr 01, load IFIFO count zero-extended at the LSB end.
REQ-023 SHALL, for a read with addr 10, load 0.
REQ-024 SHALL, for a read with addr 11, load OFIFO count in the LSBs and wr_drop at bit PACKET_WIDTH-1-clog2(DEPTH+1), all other bits 0.
REQ-025 SHALL treat a write as nicEn && nicEnWR; with addr 10 and OFIFO not full it pushes d_in; with addr 10 and OFIFO full it drops d_in and sets sticky wr_drop.
REQ-026 SHALL clear wr_drop on a write with addr 11, and ignore writes to addr 00/01.
REQ-027 SHALL, on an edge where OFIFO is non-empty && net_ro && net_polarity, load the OFIFO head into net_do, set net_so=1 and pop; otherwise net_so=0 and net_do holds its value.
REQ-028 SHALL make net_so a one-cycle pulse per packet; back-to-back sends occur only while the condition holds on consecutive edges.
REQ-029 SHALL allow push and pop on the same FIFO in one cycle: both take effect and count is unchanged; full/empty tests use the pre-edge count, so a push to a full FIFO is rejected even when a pop occurs in that cycle.
REQ-030 SHALL never let count exceed DEPTH or underflow below 0, and packet data (including all-zero packets) SHALL NOT affect status.

Reset
REQ-031 SHALL, while reset=1 at the edge, clear both FIFO pointers and counts, wr_drop, d_out=0, net_so=0 and net_do=0; net_ri=1 after reset.
REQ-032 SHALL let reset override all same-cycle push, pop and read requests; FIFO contents are don't-care after reset.
REQ-033 SHALL discard in-flight packets on reset mid-operation; the first post-reset send carries only data written after reset.

Verification
REQ-034 SHALL be verified by directed test: router pushes A,B,C,D with DEPTH=4 -> net_ri=0 after the 4th; a 5th net_si is ignored; 4 addr-00 reads return A,B,C,D; a 5th read returns 0.
REQ-035 SHALL be verified by directed test: CPU writes 0x11,0x22 with net_ro=1 and polarity toggling 1,0,1 -> net_so pulses on the polarity=1 edges only; net_do=0x11 then 0x22; OFIFO count returns to 0.
REQ-036 SHALL be verified by directed test: 5 writes with net_ro=0 -> addr-11 read shows count 4 and wr_drop=1; a write to addr 11 then reads wr_drop=0.
REQ-037 SHALL be verified by directed test: IFIFO full, net_si and an addr-00 read in the same cycle -> pop occurs, push rejected, count=3.
REQ-038 SHALL be verified by directed test: reset asserted with both FIFOs at count 2 -> next edge d_out=0, net_so=0, counts read 0, net_ri=1.
REQ-039 SHALL be verified by directed test: an all-zero packet is pushed -> addr-01 reads count 1 and the packet is delivered.
